// File: rtl/uart_shift_register.sv
// ---------------------------------------------------------------------------
// uart_shift_register
//
// Shift register with a frame controller for the UART datapath. One instance
// serialises a parallel word (transmit) or deserialises a bit stream
// (receive). A frame of WORD_LENGTH bits is started by load and advanced one
// bit per shift_en strobe.
//
// Parameters:
//   WORD_LENGTH : frame width in bits (>= 2)
//   LSB_FIRST   : 1 = shift right, bit 0 first; 0 = shift left, MSB first
//   IDLE_LEVEL  : serial_out level while no frame is active
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous clear, active-low
//   sync_reset : synchronous clear, active-high
//   load       : start a frame, capturing data_in (accepted in IDLE only)
//   data_in    : parallel word captured on an accepted load
//   shift_en   : one-cycle strobe advancing one bit (honoured in SHIFT only)
//   serial_in  : bit inserted at the far end on each shift
//   serial_out : current output bit (IDLE_LEVEL while idle)
//   data_out   : shift register contents
//   bit_count  : bits shifted in the current frame
//   busy       : frame in progress
//   done       : one-cycle pulse after the final shift
// ---------------------------------------------------------------------------
module uart_shift_register #(
    parameter int   WORD_LENGTH = 8,
    parameter bit   LSB_FIRST   = 1'b1,
    parameter logic IDLE_LEVEL  = 1'b1,
    localparam int  CW          = $clog2(WORD_LENGTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sync_reset,
    input  logic                   load,
    input  logic [WORD_LENGTH-1:0] data_in,
    input  logic                   shift_en,
    input  logic                   serial_in,
    output logic                   serial_out,
    output logic [WORD_LENGTH-1:0] data_out,
    output logic [CW-1:0]          bit_count,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [WORD_LENGTH-1:0] shreg_r;
    logic [WORD_LENGTH-1:0] shreg_s;
    logic [CW-1:0]          count_r;
    logic [CW-1:0]          count_s;
    logic                   done_r;
    logic                   done_s;

    // State, datapath and done flops; asynchronous clear to reset values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            shreg_r <= {WORD_LENGTH{1'b0}};
            count_r <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            count_r <= count_s;
            done_r  <= done_s;
        end
    end

    // Next-state and datapath update; sync_reset overrides any frame action.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        count_s = count_r;
        done_s  = 1'b0;
        if (sync_reset) begin
            state_s = ST_IDLE;
            shreg_s = {WORD_LENGTH{1'b0}};
            count_s = {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // shift_en is deliberately ignored here, even alongside load.
                    if (load) begin
                        shreg_s = data_in;
                        count_s = {CW{1'b0}};
                        state_s = ST_SHIFT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (shift_en) begin
                        if (LSB_FIRST) begin
                            shreg_s = {serial_in, shreg_r[WORD_LENGTH-1:1]};
                        end else begin
                            shreg_s = {shreg_r[WORD_LENGTH-2:0], serial_in};
                        end
                        count_s = count_r + CW'(1);
                        // Last bit of the frame: leave SHIFT and pulse done.
                        if (count_r == CW'(WORD_LENGTH - 1)) begin
                            state_s = ST_IDLE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_SHIFT;
                        end
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output bit: the end of the register facing the line, idle level otherwise.
    always_comb begin
        serial_out = IDLE_LEVEL;
        if (state_r == ST_SHIFT) begin
            if (LSB_FIRST) begin
                serial_out = shreg_r[0];
            end else begin
                serial_out = shreg_r[WORD_LENGTH-1];
            end
        end else begin
            serial_out = IDLE_LEVEL;
        end
    end

    assign busy      = (state_r == ST_SHIFT);
    assign done      = done_r;
    assign data_out  = shreg_r;
    assign bit_count = count_r;

endmodule

// File: doc/uart_shift_register.md
# uart_shift_register

Parametrised shift register with a frame controller for the UART datapath. One instance serves as the transmit serialiser (parallel in, serial out) or the receive deserialiser (serial in, parallel out). A frame of `WORD_LENGTH` bits is started by `load` and advanced one bit per `shift_en` strobe. The baud/bit-timing logic drives `shift_en`, and the framing FSM consumes `busy`/`done`.

## Interface
- `WORD_LENGTH`, 8: frame width in bits. Must be at least 2.
- `LSB_FIRST`, 1: 1 means shift right, transmit/receive bit 0 first. 0 means shift left, bit `WORD_LENGTH-1` first.
- `IDLE_LEVEL`, 1'b1: value driven on `serial_out` while no frame is active.
- `CW` (localparam) = $clog2(`WORD_LENGTH`+1).

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sync_reset`  in  1  synchronous clear, active-high.
- `load`  in  1  start a frame, capturing `data_in`.
- `data_in`  in  `WORD_LENGTH`  parallel word captured on an accepted `load`.
- `shift_en`  in  1  one-cycle strobe that advances one bit.
- `serial_in`  in  1  bit inserted at the far end on each shift.
- `serial_out`  out  1  current output bit.
- `data_out`  out  `WORD_LENGTH`  shift register contents.
- `bit_count`  out  `CW`  number of bits shifted in the current frame.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- FSM has two states, IDLE and SHIFT. Reset state is IDLE.
- Update priority: `reset` > `sync_reset` > state action.
- `sync_reset`=1 does the following at the next edge, in either state:
  - sets the reset values below;
  - state returns to IDLE;
  - pending `done` is suppressed.
- In IDLE:
  - `load`=1: register <= `data_in`, `bit_count` <= 0, state goes to SHIFT.
  - `shift_en` is ignored, including when it arrives in the same cycle as `load`.
  - With no `load`, register and `bit_count` hold.
- In SHIFT:
  - `load` is ignored.
  - `shift_en`=0: everything holds, so gaps of any length between strobes are legal.
  - `shift_en`=1 with `LSB_FIRST`=1: register <= {`serial_in`, reg[W-1:1]}.
  - `shift_en`=1 with `LSB_FIRST`=0: register <= {reg[W-2:0], `serial_in`}.
  - On each accepted shift, `bit_count` increments by 1.
  - On the `shift_en` that makes `bit_count` equal `WORD_LENGTH`: state goes to IDLE, and `done` is 1 for the following cycle only.
- `serial_out` is combinational from flops:
  - in SHIFT, reg[0] when `LSB_FIRST`=1, otherwise reg[W-1];
  - in IDLE, `IDLE_LEVEL`.
- `data_out` is the register itself.
  - After a completed receive frame, the first received bit sits at bit 0 (`LSB_FIRST`=1) or bit W-1 (`LSB_FIRST`=0).
  - `data_out` holds that value through IDLE until the next `load` or clear.
- `busy` = (state == SHIFT).
- `bit_count` holds `WORD_LENGTH` in IDLE after a completed frame, and is cleared by the next `load`.
- Counter arithmetic:
  - `bit_count` never exceeds `WORD_LENGTH`; no wrap-around is possible.
  - `CW` is wide enough to hold `WORD_LENGTH`.

## Timing
- Reset values (asynchronous `reset` or `sync_reset`):
  - register/`data_out` = 0, `bit_count` = 0, `busy` = 0, `done` = 0;
  - `serial_out` = `IDLE_LEVEL`.
- `load` accepted at edge N:
  - `busy`=1 from N;
  - `serial_out` shows the first data bit from N.
- k-th accepted `shift_en` at edge M: the next bit appears on `serial_out` from M, and `bit_count`=k from M.
- Final (W-th) shift at edge M:
  - from M: `busy`=0, `done`=1, `serial_out`=`IDLE_LEVEL`;
  - at M+1: `done`=0.
- `load` in the same cycle as `done`=1 (state IDLE) is accepted, giving back-to-back frames with no dead cycle.
- `reset` asserted mid-frame clears everything immediately, without waiting for a clock edge.
- Latency from `load` to `done` is W accepted strobes plus 0 extra cycles beyond the last strobe edge.

## Test plan
- Reset: assert `reset` during a frame.
  - Required: all outputs at reset values with no clock edge.
  - Required: `serial_out`=1 with `IDLE_LEVEL`=1.
- TX, W=8, `LSB_FIRST`=1: `load` 0xA5, then 8 `shift_en` strobes, each followed by 2 idle cycles.
  - Required: `serial_out` sequence 1,0,1,0,0,1,0,1.
  - Required: `bit_count` 1..8.
  - Required: `done` a single cycle after the 8th strobe, with `busy` low from that edge.
- RX, W=8, `LSB_FIRST`=1: `load` 0x00, then feed `serial_in` = 0,0,1,1,1,1,0,0 on 8 strobes.
  - Required: `data_out`=0x3C when `done`=1.
  - Required: the value holds afterwards.
- Priority and ignoring:
  - `load`+`shift_en` in the same IDLE cycle: frame starts with `bit_count`=0.
  - `load` 0xFF mid-frame: ignored, and the frame completes with the original data.
  - `shift_en` in IDLE: no change.
- `sync_reset` after 3 shifts of 0x5A: next edge gives `data_out`=0, `busy`=0, `bit_count`=0, and no `done` pulse.
- W=10, `LSB_FIRST`=0, `IDLE_LEVEL`=0: `load` 10'h2C3.
  - Required: `serial_out` MSB first, 1,0,1,1,0,0,0,0,1,1.
  - Required: the next `load` issued in the `done` cycle starts immediately.
